// File: rtl/i2c_reg_ctrl_pkg.sv
// Shared definitions for the I2C register controller and the slave byte engine:
// FSM state encoding, timeout fill byte and a state-class helper.
package i2c_reg_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PTR      = 3'd1,
      ST_WR_WAIT  = 3'd2,
      ST_WR_BUS   = 3'd3,
      ST_RD_WAIT  = 3'd4,
      ST_RD_BUS   = 3'd5,
      ST_RD_OFFER = 3'd6
   } state_e;

   localparam logic [7:0] TIMEOUT_FILL = 8'hFF;
   localparam int         CNT_W        = 8;

   function automatic logic is_bus_state(input state_e s);
      return (s == ST_WR_BUS) || (s == ST_RD_BUS);
   endfunction

endpackage

// File: rtl/i2c_reg_ctrl_if.sv
// Slave-engine handshakes plus internal register bus, grouped for the controller.
// master = controller side, slave = byte engine / register target side.
interface i2c_reg_ctrl_if;
   logic       i2c_start;
   logic       i2c_stop;
   logic       i2c_read;
   logic       i2c_write;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic       rd_ready;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic [7:0] bus_addr;
   logic [7:0] bus_wdata;
   logic       bus_we;
   logic       bus_re;
   logic [7:0] bus_rdata;
   logic       bus_ack;
   logic [7:0] ptr;
   logic       err_timeout;

   modport master (
      input  i2c_start, i2c_stop, i2c_read, i2c_write,
      input  wr_valid, wr_data, rd_ready, bus_rdata, bus_ack,
      output wr_ready, rd_valid, rd_data, bus_addr, bus_wdata,
      output bus_we, bus_re, ptr, err_timeout
   );

   modport slave (
      output i2c_start, i2c_stop, i2c_read, i2c_write,
      output wr_valid, wr_data, rd_ready, bus_rdata, bus_ack,
      input  wr_ready, rd_valid, rd_data, bus_addr, bus_wdata,
      input  bus_we, bus_re, ptr, err_timeout
   );
endinterface

// File: rtl/i2c_reg_ctrl_timeout.sv
// Loadable down-counter with clear/enable; expire_o is a combinational pulse in
// the last enabled cycle before the count would reach zero (no backpressure).
module bus_timeout #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         expire_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (load_i)
         cnt_d = load_val_i;
      else if (en_i && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!resetn)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expire_o = en_i && (cnt_q == W'(1));

endmodule

// File: rtl/i2c_reg_ctrl.sv
// Pointer-protocol register controller: one bus beat per I2C data byte, registered strobes.
// Read: rd_ready -> rd_valid in 2 cycles + ack latency; write: accept -> next wr_ready likewise.
module i2c_reg_ctrl
   import i2c_reg_ctrl_pkg::*;
#(
   parameter int         TIMEOUT   = 255,
   parameter logic [7:0] PTR_RESET = 8'h00
) (
   input  logic           clk,
   input  logic           resetn,
   i2c_reg_ctrl_if.master io
);

   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

   state_e     state_q, state_d;
   logic [7:0] ptr_q, ptr_d;
   logic [7:0] wdata_q, wdata_d;
   logic [7:0] rdata_q, rdata_d;
   logic       we_q, we_d;
   logic       re_q, re_d;
   logic       abort_q, abort_d;
   logic       err_q, err_d;
   logic       wr_ready_c;

   logic ev, strobe_q, ack_hit, expire, done, in_bus;

   assign ev       = io.i2c_start | io.i2c_stop;
   assign strobe_q = we_q | re_q;
   assign in_bus   = is_bus_state(state_q);
   // An ack only counts while our strobe is actually on the bus.
   assign ack_hit  = strobe_q & io.bus_ack;
   assign done     = ack_hit | expire;

   bus_timeout #(.W(CNT_W)) u_timeout (
      .clk        (clk),
      .resetn     (resetn),
      .clr_i      (!in_bus),
      .load_i     (in_bus && !strobe_q),
      .load_val_i (TO_VAL),
      .en_i       (strobe_q && !io.bus_ack),
      .expire_o   (expire)
   );

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      abort_d    = abort_q;
      we_d       = 1'b0;
      re_d       = 1'b0;
      err_d      = expire;
      wr_ready_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!ev) begin
               if (io.i2c_write)
                  state_d = ST_PTR;
               else if (io.i2c_read)
                  state_d = ST_RD_WAIT;
            end
         end
         ST_PTR: begin
            if (ev)
               state_d = ST_IDLE;
            else if (io.wr_valid) begin
               wr_ready_c = 1'b1;
               ptr_d      = io.wr_data;
               state_d    = ST_WR_WAIT;
            end
         end
         ST_WR_WAIT: begin
            if (ev)
               state_d = ST_IDLE;
            else if (io.wr_valid) begin
               wr_ready_c = 1'b1;
               wdata_d    = io.wr_data;
               state_d    = ST_WR_BUS;
            end
         end
         ST_WR_BUS: begin
            // Stop/start never cuts a bus beat; the write still commits.
            if (done) begin
               ptr_d   = ptr_q + 8'd1;
               abort_d = 1'b0;
               state_d = (abort_q || ev) ? ST_IDLE : ST_WR_WAIT;
            end else begin
               we_d = 1'b1;
               if (ev)
                  abort_d = 1'b1;
            end
         end
         ST_RD_WAIT: begin
            if (ev)
               state_d = ST_IDLE;
            else if (io.rd_ready)
               state_d = ST_RD_BUS;
         end
         ST_RD_BUS: begin
            if (done) begin
               abort_d = 1'b0;
               if (abort_q || ev)
                  state_d = ST_IDLE;
               else begin
                  rdata_d = ack_hit ? io.bus_rdata : TIMEOUT_FILL;
                  state_d = ST_RD_OFFER;
               end
            end else begin
               re_d = 1'b1;
               if (ev)
                  abort_d = 1'b1;
            end
         end
         ST_RD_OFFER: begin
            if (ev)
               state_d = ST_IDLE;
            else if (io.rd_ready) begin
               ptr_d   = ptr_q + 8'd1;
               state_d = ST_RD_WAIT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         ptr_q   <= PTR_RESET;
         wdata_q <= 8'h00;
         rdata_q <= 8'h00;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
         abort_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         we_q    <= we_d;
         re_q    <= re_d;
         abort_q <= abort_d;
         err_q   <= err_d;
      end
   end

   assign io.wr_ready    = wr_ready_c;
   assign io.rd_valid    = (state_q == ST_RD_OFFER);
   assign io.rd_data     = rdata_q;
   assign io.bus_addr    = ptr_q;
   assign io.bus_wdata   = wdata_q;
   assign io.bus_we      = we_q;
   assign io.bus_re      = re_q;
   assign io.ptr         = ptr_q;
   assign io.err_timeout = err_q;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Directed bench for i2c_reg_ctrl: a register-target responder with programmable ack delay
// plus a second instance with TIMEOUT=4 for the timeout scenario.
module tb_i2c_reg_ctrl;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      bit         we;
   } txn_t;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   i2c_reg_ctrl_if bif ();
   i2c_reg_ctrl_if tif ();

   i2c_reg_ctrl #(.PTR_RESET(8'hA5)) dut (.clk(clk), .resetn(resetn), .io(bif));
   i2c_reg_ctrl #(.TIMEOUT(4))       dut_to (.clk(clk), .resetn(resetn), .io(tif));

   int checks = 0;
   int errors = 0;
   int ack_dly = 0;
   bit ack_off = 1'b0;
   int age = 0;
   int wr_ready_cnt = 0, we_cyc = 0, re_cyc = 0, re_cyc_t = 0, err_cnt_t = 0;
   txn_t log_q[$];
   logic [7:0] rmem [256];

   // Register target model and cycle counters, evaluated away from the active edge.
   always @(negedge clk) begin
      if (bif.wr_ready) wr_ready_cnt++;
      if (bif.bus_we) we_cyc++;
      if (bif.bus_re) re_cyc++;
      if (tif.bus_re) re_cyc_t++;
      if (tif.err_timeout) err_cnt_t++;
      if (bif.bus_we || bif.bus_re) begin
         if (!ack_off && age >= ack_dly) begin
            bif.bus_ack   = 1'b1;
            bif.bus_rdata = rmem[bif.bus_addr];
            log_q.push_back('{addr: bif.bus_addr,
                              data: bif.bus_we ? bif.bus_wdata : rmem[bif.bus_addr],
                              we: bif.bus_we});
         end else begin
            bif.bus_ack = 1'b0;
         end
         age++;
      end else begin
         bif.bus_ack = 1'b0;
         age = 0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic ev(input bit st, input bit sp, input bit rd, input bit wr);
      bif.i2c_start = st; bif.i2c_stop = sp; bif.i2c_read = rd; bif.i2c_write = wr;
      tick();
      bif.i2c_start = 1'b0; bif.i2c_stop = 1'b0; bif.i2c_read = 1'b0; bif.i2c_write = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, output bit ok, output int n);
      ok = 1'b0; n = 0;
      bif.wr_valid = 1'b1; bif.wr_data = b;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (bif.wr_ready) ok = 1'b1; else n++;
         tick();
      end
      bif.wr_valid = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      bif.wr_valid = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (bif.ptr !== 8'hA5) begin errors++; $display("FAIL reset_ptr got %h want a5", bif.ptr); end
      checks++; if (tif.ptr !== 8'h00) begin errors++; $display("FAIL reset_ptr_to got %h want 00", tif.ptr); end
      checks++; if ({bif.bus_we, bif.bus_re, bif.rd_valid, bif.err_timeout, bif.wr_ready} !== 5'b0) begin
         errors++; $display("FAIL reset_strobes got %b want 00000",
                            {bif.bus_we, bif.bus_re, bif.rd_valid, bif.err_timeout, bif.wr_ready}); end
      checks++; if ({bif.rd_data, bif.bus_wdata} !== 16'h0000) begin
         errors++; $display("FAIL reset_data got %h want 0000", {bif.rd_data, bif.bus_wdata}); end
      tick();
      resetn = 1'b1;
      bif.wr_valid = 1'b0;
      tick();
   endtask

   task automatic test_write();
      bit ok; int n;
      log_q.delete(); wr_ready_cnt = 0; ack_dly = 1;
      ev(0, 0, 0, 1);
      send_byte(8'h10, ok, n);
      checks++; if (!ok) begin errors++; $display("FAIL wr_ptr_accept got 0 want 1"); end
      send_byte(8'hAA, ok, n);
      checks++; if (!ok || n != 0) begin errors++; $display("FAIL wr_aa_accept ok %0d wait %0d want 1/0", ok, n); end
      send_byte(8'hBB, ok, n);
      checks++; if (!ok || n != 3) begin errors++; $display("FAIL wr_turnaround ok %0d wait %0d want 1/3", ok, n); end
      repeat (8) tick();
      checks++; if (log_q.size() != 2) begin errors++; $display("FAIL wr_beats got %0d want 2", log_q.size()); end
      else begin
         checks++; if ({log_q[0].addr, log_q[0].data, log_q[0].we} !== {8'h10, 8'hAA, 1'b1}) begin
            errors++; $display("FAIL wr_beat0 got %h/%h/%0d want 10/aa/1", log_q[0].addr, log_q[0].data, log_q[0].we); end
         checks++; if ({log_q[1].addr, log_q[1].data, log_q[1].we} !== {8'h11, 8'hBB, 1'b1}) begin
            errors++; $display("FAIL wr_beat1 got %h/%h/%0d want 11/bb/1", log_q[1].addr, log_q[1].data, log_q[1].we); end
      end
      checks++; if (bif.ptr !== 8'h12) begin errors++; $display("FAIL wr_ptr got %h want 12", bif.ptr); end
      checks++; if (wr_ready_cnt != 3) begin errors++; $display("FAIL wr_ready_pulses got %0d want 3", wr_ready_cnt); end
      ev(0, 1, 0, 0);
   endtask

   task automatic test_read_wrap();
      bit ok; int n; int got; int first;
      logic [7:0] d [3];
      ev(0, 0, 0, 1);
      send_byte(8'hFE, ok, n);
      ev(0, 1, 0, 0);
      checks++; if (!ok || bif.ptr !== 8'hFE) begin errors++; $display("FAIL rd_setptr got %h want fe", bif.ptr); end
      rmem[8'hFE] = 8'h01; rmem[8'hFF] = 8'h02; rmem[8'h00] = 8'h03;
      log_q.delete(); ack_dly = 0;
      ev(0, 0, 1, 0);
      bif.rd_ready = 1'b1;
      got = 0; first = -1;
      for (int i = 0; i < 60 && got < 3; i++) begin
         @(negedge clk);
         if (bif.rd_valid) begin
            d[got] = bif.rd_data;
            if (got == 0) first = i;
            got++;
         end
      end
      tick();
      bif.rd_ready = 1'b0;
      tick();
      checks++; if (got != 3) begin errors++; $display("FAIL rd_count got %0d want 3", got); end
      else begin
         checks++; if ({d[0], d[1], d[2]} !== 24'h010203) begin
            errors++; $display("FAIL rd_data got %h %h %h want 01 02 03", d[0], d[1], d[2]); end
      end
      checks++; if (first != 3) begin errors++; $display("FAIL rd_latency got %0d want 3", first); end
      checks++; if (log_q.size() != 3) begin errors++; $display("FAIL rd_beats got %0d want 3", log_q.size()); end
      else begin
         checks++; if ({log_q[0].addr, log_q[1].addr, log_q[2].addr, log_q[0].we, log_q[1].we, log_q[2].we}
                       !== {8'hFE, 8'hFF, 8'h00, 3'b000}) begin
            errors++; $display("FAIL rd_addrs got %h %h %h want fe ff 00", log_q[0].addr, log_q[1].addr, log_q[2].addr); end
      end
      checks++; if (bif.ptr !== 8'h01) begin errors++; $display("FAIL rd_wrap_ptr got %h want 01", bif.ptr); end
      ev(0, 1, 0, 0);
   endtask

   task automatic test_repeated_start();
      bit ok; int n; bit found; logic [7:0] d;
      rmem[8'h40] = 8'h5A; log_q.delete(); we_cyc = 0;
      ev(0, 0, 0, 1);
      send_byte(8'h40, ok, n);
      ev(1, 0, 0, 0);
      ev(0, 0, 1, 0);
      bif.rd_ready = 1'b1;
      found = 1'b0; d = 8'h00;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         if (bif.rd_valid) begin found = 1'b1; d = bif.rd_data; end
      end
      tick();
      bif.rd_ready = 1'b0;
      repeat (2) tick();
      checks++; if (!ok || !found || d !== 8'h5A) begin
         errors++; $display("FAIL rs_data found %0d got %h want 5a", found, d); end
      checks++; if (log_q.size() != 1) begin errors++; $display("FAIL rs_beats got %0d want 1", log_q.size()); end
      else begin
         checks++; if ({log_q[0].addr, log_q[0].we} !== {8'h40, 1'b0}) begin
            errors++; $display("FAIL rs_addr got %h/%0d want 40/0", log_q[0].addr, log_q[0].we); end
      end
      checks++; if (we_cyc != 0) begin errors++; $display("FAIL rs_no_write got %0d want 0", we_cyc); end
      checks++; if (bif.ptr !== 8'h41) begin errors++; $display("FAIL rs_ptr got %h want 41", bif.ptr); end
      ev(0, 1, 0, 0);
   endtask

   task automatic test_timeout();
      bit found; logic [7:0] d; logic re_at_err;
      re_cyc_t = 0; err_cnt_t = 0; re_at_err = 1'b1;
      tif.i2c_read = 1'b1;
      tick();
      tif.i2c_read = 1'b0;
      tif.rd_ready = 1'b1;
      found = 1'b0; d = 8'h00;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (tif.err_timeout) re_at_err = tif.bus_re;
         if (tif.rd_valid) begin found = 1'b1; d = tif.rd_data; end
      end
      tick();
      tif.rd_ready = 1'b0;
      repeat (2) tick();
      checks++; if (!found || d !== 8'hFF) begin errors++; $display("FAIL to_fill found %0d got %h want ff", found, d); end
      checks++; if (re_cyc_t != 4) begin errors++; $display("FAIL to_re_cycles got %0d want 4", re_cyc_t); end
      checks++; if (err_cnt_t != 1) begin errors++; $display("FAIL to_err_pulses got %0d want 1", err_cnt_t); end
      checks++; if (re_at_err !== 1'b0) begin errors++; $display("FAIL to_re_at_err got %b want 0", re_at_err); end
      checks++; if (tif.ptr !== 8'h01) begin errors++; $display("FAIL to_ptr got %h want 01", tif.ptr); end
      tif.i2c_stop = 1'b1;
      tick();
      tif.i2c_stop = 1'b0;
   endtask

   task automatic test_stop_mid();
      bit ok1, ok2; int n; bit seen;
      log_q.delete(); we_cyc = 0; ack_dly = 6;
      ev(0, 0, 0, 1);
      send_byte(8'h20, ok1, n);
      send_byte(8'h77, ok2, n);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = bif.bus_we;
      end
      tick();
      ev(0, 1, 0, 0);
      for (int i = 0; i < 30 && bif.bus_we; i++) @(negedge clk);
      tick();
      checks++; if (!ok1 || !ok2 || !seen) begin errors++; $display("FAIL sm_setup got %0d%0d%0d want 111", ok1, ok2, seen); end
      checks++; if (we_cyc != 7) begin errors++; $display("FAIL sm_we_held got %0d want 7", we_cyc); end
      checks++; if (log_q.size() != 1) begin errors++; $display("FAIL sm_beats got %0d want 1", log_q.size()); end
      else begin
         checks++; if ({log_q[0].addr, log_q[0].data} !== {8'h20, 8'h77}) begin
            errors++; $display("FAIL sm_beat got %h/%h want 20/77", log_q[0].addr, log_q[0].data); end
      end
      checks++; if (bif.ptr !== 8'h21) begin errors++; $display("FAIL sm_ptr got %h want 21", bif.ptr); end
      wr_ready_cnt = 0;
      bif.wr_valid = 1'b1; bif.wr_data = 8'h99;
      repeat (4) @(negedge clk);
      tick();
      bif.wr_valid = 1'b0;
      checks++; if (wr_ready_cnt != 0) begin errors++; $display("FAIL sm_idle_ready got %0d want 0", wr_ready_cnt); end
      // Byte colliding with stop while in PTR must be dropped.
      ev(0, 0, 0, 1);
      bif.wr_valid = 1'b1; bif.wr_data = 8'h66; bif.i2c_stop = 1'b1;
      @(negedge clk);
      checks++; if (bif.wr_ready !== 1'b0) begin errors++; $display("FAIL coll_ready got %b want 0", bif.wr_ready); end
      tick();
      bif.i2c_stop = 1'b0;
      @(negedge clk);
      checks++; if (bif.wr_ready !== 1'b0) begin errors++; $display("FAIL coll_idle_ready got %b want 0", bif.wr_ready); end
      tick();
      bif.wr_valid = 1'b0;
      checks++; if (bif.ptr !== 8'h21) begin errors++; $display("FAIL coll_ptr got %h want 21", bif.ptr); end
   endtask

   task automatic test_reset_mid_read();
      bit seen;
      ack_off = 1'b1;
      ev(0, 0, 1, 0);
      bif.rd_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = bif.bus_re;
      end
      tick();
      resetn = 1'b0;
      bif.rd_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++; if (!seen) begin errors++; $display("FAIL rmr_bus_re got 0 want 1"); end
      checks++; if (bif.bus_re !== 1'b0) begin errors++; $display("FAIL rmr_re_drop got %b want 0", bif.bus_re); end
      checks++; if (bif.ptr !== 8'hA5) begin errors++; $display("FAIL rmr_ptr got %h want a5", bif.ptr); end
      checks++; if ({bif.bus_we, bif.rd_valid, bif.err_timeout, bif.rd_data, bif.bus_wdata} !== 19'h0) begin
         errors++; $display("FAIL rmr_outputs got %b/%b/%b/%h/%h want 0/0/0/00/00",
                            bif.bus_we, bif.rd_valid, bif.err_timeout, bif.rd_data, bif.bus_wdata); end
      tick();
      resetn = 1'b1;
      ack_off = 1'b0;
      tick();
   endtask

   initial begin
      bif.i2c_start = 1'b0; bif.i2c_stop = 1'b0; bif.i2c_read = 1'b0; bif.i2c_write = 1'b0;
      bif.wr_valid = 1'b0; bif.wr_data = 8'h00; bif.rd_ready = 1'b0;
      bif.bus_rdata = 8'h00; bif.bus_ack = 1'b0;
      tif.i2c_start = 1'b0; tif.i2c_stop = 1'b0; tif.i2c_read = 1'b0; tif.i2c_write = 1'b0;
      tif.wr_valid = 1'b0; tif.wr_data = 8'h00; tif.rd_ready = 1'b0;
      tif.bus_rdata = 8'h00; tif.bus_ack = 1'b0;
      resetn = 1'b0;
      for (int i = 0; i < 256; i++) rmem[i] = 8'(i) ^ 8'h3C;
      test_reset();
      test_write();
      test_read_wrap();
      test_repeated_start();
      test_timeout();
      test_stop_mid();
      test_reset_mid_read();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
